// File: rtl/cpu_irq_pkg.sv
// Shared types and helpers for the CP0 hardware interrupt sequencer.
package cpu_irq_pkg;

  localparam int unsigned N_IRQ_DEF = 8;
  localparam int unsigned VEC_W     = 3;

  typedef enum logic [0:0] {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_t;

  typedef struct packed {
    logic             valid;
    logic [VEC_W-1:0] idx;
  } prio_t;

  // Lowest set index wins; index 0 is the highest priority line.
  function automatic prio_t prio_enc(input logic [7:0] v);
    prio_t r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = VEC_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_irq_sync.sv
// One interrupt line: metastability chain plus rising-edge detector.
module cpu_irq_sync
  import cpu_irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic edge_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Hardware interrupt sequencer: edge capture, masking, fixed-priority pick,
// req/ack handshake to EX and an in-service stack retired by eret.
module cpu_irq_ctrl
  import cpu_irq_pkg::*;
#(
  parameter int unsigned N_IRQ       = N_IRQ_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_IRQ-1:0] hw_irq,
  input  logic [N_IRQ-1:0] int_mask,
  input  logic             int_global_en,
  input  logic             irq_ack,
  input  logic             eret,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vector,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic [CNT_W-1:0] irq_count
);

  irq_state_t       state_q, state_d;
  logic             req_d;
  logic [VEC_W-1:0] vec_d;
  logic [N_IRQ-1:0] edge_c;
  logic [N_IRQ-1:0] elig_c;
  logic [N_IRQ-1:0] vec_onehot_c;
  logic [N_IRQ-1:0] pend_d;
  logic [N_IRQ-1:0] isv_d;
  prio_t            cand_c;
  prio_t            isv_top_c;
  logic             cand_ok_c;
  logic             vec_live_c;
  logic             take_c;

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_sync
    cpu_irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .clr    (clr),
      .d      (hw_irq[gi]),
      .edge_c (edge_c[gi])
    );
  end

  // Only a line strictly more urgent than the innermost active handler may nest.
  always_comb begin
    elig_c       = pending & int_mask & {N_IRQ{int_global_en}};
    cand_c       = prio_enc(8'(elig_c));
    isv_top_c    = prio_enc(8'(in_service));
    cand_ok_c    = cand_c.valid && (!isv_top_c.valid || (cand_c.idx < isv_top_c.idx));
    vec_live_c   = pending[irq_vector] & int_mask[irq_vector] & int_global_en;
    take_c       = (state_q == IRQ_REQ) && irq_ack;
    vec_onehot_c = N_IRQ'(1) << irq_vector;
  end

  // Handshake FSM; the vector is frozen for the whole request.
  always_comb begin
    state_d = state_q;
    req_d   = irq_req;
    vec_d   = irq_vector;
    case (state_q)
      IRQ_IDLE: begin
        if (cand_ok_c) begin
          state_d = IRQ_REQ;
          req_d   = 1'b1;
          vec_d   = cand_c.idx;
        end
      end
      IRQ_REQ: begin
        if (irq_ack || !vec_live_c) begin
          state_d = IRQ_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IRQ_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // A fresh edge in the ack cycle survives the clear, so the second event is kept.
  always_comb begin
    pend_d = (pending & ~(take_c ? vec_onehot_c : '0)) | edge_c;
    isv_d  = in_service;
    if (eret && isv_top_c.valid) begin
      isv_d = isv_d & ~(N_IRQ'(1) << isv_top_c.idx);
    end
    if (take_c) begin
      isv_d = isv_d | vec_onehot_c;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IRQ_IDLE;
      irq_req    <= 1'b0;
      irq_vector <= '0;
      pending    <= '0;
      in_service <= '0;
      irq_count  <= '0;
    end else begin
      state_q    <= state_d;
      irq_req    <= req_d;
      irq_vector <= vec_d;
      pending    <= pend_d;
      in_service <= isv_d;
      if (take_c) begin
        irq_count <= irq_count + CNT_W'(1);
      end
    end
  end

endmodule
